// File: rtl/lsu_dmem_pkg.sv
// Shared definitions for the load/store unit.
// - RV32I funct3 codes for loads and stores
// - LSU FSM state encoding
// - Byte-strobe constants
// - Helper that flags H/W accesses whose address is not naturally aligned
package lsu_dmem_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  localparam logic [3:0] StrbNone   = 4'b0000;
  localparam logic [3:0] StrbByte0  = 4'b0001;
  localparam logic [3:0] StrbLoHalf = 4'b0011;
  localparam logic [3:0] StrbHiHalf = 4'b1100;
  localparam logic [3:0] StrbAll    = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitRsp
  } lsu_state_e;

  function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3Lh, F3Lhu: mis = addr_lo[0];
      F3Lw:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
// - req/we/addr/wdata/wstrb : request, held stable until req && ready
// - ready                   : memory accepts the request
// - rvalid/rdata            : read data valid or write acknowledged
interface lsu_dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/lsu_store_align.sv
// Combinational store alignment: funct3 + low address bits + rs2 -> byte strobes and
// lane-replicated write data. Loads (store_i = 0) get no strobes.
// - funct3_i  : RV32I funct3
// - store_i   : op is a store
// - addr_lo_i : effective address bits [1:0]
// - wdata_i   : store source data
// - wstrb_o   : byte strobes
// - wdata_o   : replicated write data
module lsu_store_align
  import lsu_dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        store_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    wstrb_o = StrbAll;
    wdata_o = wdata_i;
    case (funct3_i)
      F3Sb: begin
        wstrb_o = StrbByte0 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      F3Sh: begin
        wstrb_o = addr_lo_i[1] ? StrbHiHalf : StrbLoHalf;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        wstrb_o = StrbAll;
        wdata_o = wdata_i;
      end
    endcase
    if (!store_i) begin
      wstrb_o = StrbNone;
    end
  end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit: takes a memory op from execute, registers the aligned word request,
// runs the dmem handshake with a response watchdog and returns the raw read word with a
// one-cycle strobe. Lane extraction / sign extension is left to write-back.
// Ports:
// - clk_i, rst_ni          : clock, asynchronous active-low reset
// - ex_*_i                 : op from execute (held by execute while lsu_busy_o)
// - dmem                   : data-memory bus (master side)
// - dmem_read_data_o       : registered read word, held until the next response
// - dmem_write_valid_o     : one-cycle response strobe
// - lsu_busy_o             : high whenever the FSM is not idle
// - lsu_bus_err_o          : one-cycle pulse on watchdog expiry (or misaligned trap)
// Configuration: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses without a
// bus request; by default they access the containing word.
module lsu_dmem
  import lsu_dmem_pkg::*;
#(
  parameter int unsigned Timeout = 16,
  parameter int unsigned CntW    = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ex_valid_i,
  input  logic              ex_load_i,
  input  logic              ex_store_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [31:0]       ex_addr_i,
  input  logic [31:0]       ex_wdata_i,
  lsu_dmem_if.master        dmem,
  output logic [31:0]       dmem_read_data_o,
  output logic              dmem_write_valid_o,
  output logic              lsu_busy_o,
  output logic              lsu_bus_err_o
);

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            we_q;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [3:0]      wstrb_q;
  logic            wvalid_q, err_q;
  logic [3:0]      al_wstrb;
  logic [31:0]     al_wdata;
  logic            ex_go, misalign, timeout;

  lsu_store_align u_align (
    .funct3_i  (ex_funct3_i),
    .store_i   (ex_store_i),
    .addr_lo_i (ex_addr_i[1:0]),
    .wdata_i   (ex_wdata_i),
    .wstrb_o   (al_wstrb),
    .wdata_o   (al_wdata)
  );

  assign ex_go   = ex_valid_i && (ex_load_i || ex_store_i);
  assign timeout = (cnt_q == CntW'(Timeout - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(ex_funct3_i, ex_addr_i[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a trapped misaligned op completes from idle without leaving it
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (ex_go && !misalign) state_d = StReq;
      StReq:     if (dmem.ready) state_d = StWaitRsp;
      StWaitRsp: if (dmem.rvalid || timeout) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Request fields, watchdog and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      wvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ex_go) begin
            if (misalign) begin
              wvalid_q <= 1'b1;
              err_q    <= 1'b1;
              rdata_q  <= '0;
            end else begin
              we_q    <= ex_store_i;
              addr_q  <= {ex_addr_i[31:2], 2'b00};
              wdata_q <= al_wdata;
              wstrb_q <= al_wstrb;
            end
          end
        end
        StReq: begin
          if (dmem.ready) cnt_q <= '0;
        end
        StWaitRsp: begin
          cnt_q <= cnt_q + CntW'(1);
          // rvalid has priority over an expiring watchdog
          if (dmem.rvalid) begin
            rdata_q  <= dmem.rdata;
            wvalid_q <= 1'b1;
          end else if (timeout) begin
            rdata_q  <= '0;
            wvalid_q <= 1'b1;
            err_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    dmem.req           = (state_q == StReq);
    dmem.we            = we_q;
    dmem.addr          = addr_q;
    dmem.wdata         = wdata_q;
    dmem.wstrb         = wstrb_q;
    dmem_read_data_o   = rdata_q;
    dmem_write_valid_o = wvalid_q;
    lsu_bus_err_o      = err_q;
    lsu_busy_o         = (state_q != StIdle);
  end

endmodule
